// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one line-wide Data_Memory between the instruction
// cache (port 0) and the data cache (port 1), with a no-acknowledge watchdog.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 256,
  parameter int TIMEOUT = 64,
  parameter int TO_W    = 7
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_enable_i,
  input  logic              m0_write_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_data_i,
  output logic              m0_ack_o,
  output logic [DATA_W-1:0] m0_data_o,
  input  logic              m1_enable_i,
  input  logic              m1_write_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_data_i,
  output logic              m1_ack_o,
  output logic [DATA_W-1:0] m1_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic [1:0]        grant_o,
  output logic              timeout_err_o
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1, DONE} state_t;

  state_t          state;
  state_t          state_next;
  logic            last_grant;
  logic            last_grant_next;
  logic [TO_W-1:0] wdog;
  logic            wdog_hit;
  logic            load0;
  logic            load1;
  logic            timeout_set;
  logic            in_gnt0;
  logic            in_gnt1;

  assign in_gnt0 = (state == GNT0);
  assign in_gnt1 = (state == GNT1);

  // Counter value in the last allowed granted cycle; TIMEOUT of 0 never fires.
  assign wdog_hit = (TIMEOUT != 0) && (wdog == TO_W'(TIMEOUT - 1));

  always_comb begin
    state_next      = state;
    last_grant_next = last_grant;
    load0           = 1'b0;
    load1           = 1'b0;
    timeout_set     = 1'b0;
    case (state)
      IDLE: begin
        // Port 0 wins when alone, or on a tie when port 1 was served last.
        if (m0_enable_i && (!m1_enable_i || last_grant)) begin
          state_next      = GNT0;
          load0           = 1'b1;
          last_grant_next = 1'b0;
        end else if (m1_enable_i) begin
          state_next      = GNT1;
          load1           = 1'b1;
          last_grant_next = 1'b1;
        end
      end
      GNT0, GNT1: begin
        if (mem_ack_i) begin
          state_next = DONE;
        end else if (wdog_hit) begin
          state_next  = DONE;
          timeout_set = 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= IDLE;
      last_grant    <= 1'b1;
      wdog          <= '0;
      mem_write_o   <= 1'b0;
      mem_addr_o    <= '0;
      mem_data_o    <= '0;
      timeout_err_o <= 1'b0;
    end else begin
      state      <= state_next;
      last_grant <= last_grant_next;
      if ((in_gnt0 || in_gnt1) && (state_next == state)) begin
        wdog <= wdog + TO_W'(1);
      end else begin
        wdog <= '0;
      end
      if (load0) begin
        mem_write_o <= m0_write_i;
        mem_addr_o  <= m0_addr_i;
        mem_data_o  <= m0_data_i;
      end else if (load1) begin
        mem_write_o <= m1_write_i;
        mem_addr_o  <= m1_addr_i;
        mem_data_o  <= m1_data_i;
      end
      if (timeout_set) begin
        timeout_err_o <= 1'b1;
      end
    end
  end

  assign mem_enable_o = in_gnt0 | in_gnt1;
  assign grant_o      = {in_gnt1, in_gnt0};
  assign m0_ack_o     = in_gnt0 & mem_ack_i;
  assign m1_ack_o     = in_gnt1 & mem_ack_i;
  assign m0_data_o    = in_gnt0 ? mem_data_i : '0;
  assign m1_data_o    = in_gnt1 ? mem_data_i : '0;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter that shares the single 256-bit line-wide Data_Memory between the instruction cache (port 0) and the data cache (port 1).
- Sits between both caches' memory-side interfaces and Data_Memory.
- Grants one whole line transaction at a time using round-robin priority.
- Adds a watchdog that flags a memory that never acknowledges.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 256, line width.
- TIMEOUT, 64, max cycles from grant to mem_ack_i before abort; 0 disables the watchdog.
- TO_W, 7, watchdog counter width; must hold TIMEOUT.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  synchronous active-high reset.
- m0_enable_i  in  1  port 0 request.
- m0_write_i  in  1  port 0 write (1) / read (0).
- m0_addr_i  in  ADDR_W  port 0 line address.
- m0_data_i  in  DATA_W  port 0 write line.
- m0_ack_o  out  1  port 0 transaction done.
- m0_data_o  out  DATA_W  port 0 read line.
- m1_enable_i, m1_write_i, m1_addr_i, m1_data_i, m1_ack_o, m1_data_o: same as port 0, for port 1.
- mem_enable_o  out  1  Data_Memory request.
- mem_write_o  out  1  Data_Memory write.
- mem_addr_o  out  ADDR_W  Data_Memory address.
- mem_data_o  out  DATA_W  Data_Memory write line.
- mem_ack_i  in  1  Data_Memory done (1-cycle pulse).
- mem_data_i  in  DATA_W  Data_Memory read line.
- grant_o  out  2  one-hot current owner; 00 when idle.
- timeout_err_o  out  1  sticky watchdog error.

Behaviour:
- Requester contract: mX_write_i, mX_addr_i and mX_data_i are held stable while mX_enable_i=1, until the cycle after mX_ack_o. The requester then drops enable or presents a new request.
- FSM states: IDLE, GNT0, GNT1, DONE.
- IDLE:
  - Only m0_enable_i=1 -> GNT0.
  - Only m1_enable_i=1 -> GNT1.
  - Both requesting -> go to the port not equal to last_grant.
  - Neither -> stay in IDLE.
  - On the transition, latch the winner's write/addr/data into mem_*_o registers and set last_grant.
- GNTx:
  - mem_enable_o=1 and grant_o one-hot for port x.
  - Watchdog counts cycles in GNTx.
  - mem_ack_i=1 -> mx_ack_o=1 in the same cycle (combinational from mem_ack_i gated by grant); mx_data_o=mem_data_i; next state DONE.
  - Watchdog reaches TIMEOUT with no ack -> timeout_err_o<=1, next state DONE, no ack to the master.
- DONE:
  - One bubble cycle, with mem_enable_o=0 and grant_o=00.
  - Next state is IDLE. The requester's enable may still read 1 in this cycle and is ignored.
- Latency:
  - Request seen at edge N -> mem_enable_o high from cycle N+1.
  - Back-to-back requests from the same port cost 2 idle cycles (DONE + IDLE).
- Data outputs:
  - Non-granted port: mY_ack_o=0 always.
  - mY_data_o is don't-care but driven to 0.
  - Granted port: mx_data_o = mem_data_i (pass-through).
- last_grant resets to 1, so port 0 wins the first tie.
- A mem_ack_i arriving in IDLE or DONE is ignored and produces no mX_ack_o.
- Reset values:
  - State IDLE, last_grant=1, watchdog=0.
  - mem_enable_o=0, mem_write_o=0, mem_addr_o=0, mem_data_o=0.
  - grant_o=00, m0_ack_o=0, m1_ack_o=0, timeout_err_o=0.
- Reset mid-transaction: all of the above take effect at the next edge. Any ack arriving after reset is ignored.
- timeout_err_o clears only on rst_i.
- A write transaction never drives mX_data_o meaningfully. Both ports' write data is forwarded unmodified (full line, no byte enables).

Test Plan:
- Single read, port 0: m0 read addr 0x0000_0040, memory acks 10 cycles after enable -> mem_enable_o rises 1 cycle after the request, mem_addr_o=0x40, m0_ack_o pulses with mem_ack_i, m0_data_o equals the memory line, grant_o=01 during the transaction and 00 in DONE.
- Simultaneous requests after reset: m0 read 0x100 and m1 write 0x200 (data pattern 0xA5 repeated) in the same cycle -> port 0 served first. Then port 1 served with mem_write_o=1, mem_addr_o=0x200 and the data pattern intact. m0_ack_o and m1_ack_o are never both high.
- Round-robin fairness: both ports hold requests continuously for 6 transactions -> grant sequence 0,1,0,1,0,1; each transaction separated by exactly 2 non-enabled cycles.
- Watchdog: TIMEOUT=8, m1 read, memory never acks -> after 8 GNT1 cycles timeout_err_o=1 (stays set), mem_enable_o drops, m1_ack_o stays 0. A following m0 request completes normally.
- Reset mid-operation: assert rst_i for 1 cycle while in GNT1, then deliver a late mem_ack_i -> all outputs at reset values next edge, no mX_ack_o from the late ack, and the next tie goes to port 0.
- Stray ack: pulse mem_ack_i while idle -> no m0_ack_o or m1_ack_o, state stays IDLE.
